// File: rtl/alu_shift_seq.sv
`default_nettype none
//============================================================================
// Module      : alu_shift_seq
// Description : Multi-cycle shift-then-ALU datapath with valid/ready
//               handshakes on input and output. Operand A is shifted one
//               bit per clock (left, logical right or arithmetic right) by
//               a programmable amount. It is then combined with B by a
//               3-bit opcode that yields registered NZCV flags, with an
//               optional two's-complement to sign-magnitude conversion of
//               the result.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk         : clock, all state updates on the rising edge
//   reset_n     : asynchronous active-low reset
//   in_valid    : request valid
//   in_ready    : block idle and able to accept a request
//   a, b        : operand to be shifted / second ALU operand
//   ALUControl  : opcode (ADD SUB AND OR XOR NOR passS passB)
//   shamt       : shift amount
//   dir         : 0 = left, 1 = right
//   arith       : right shifts only, 1 = sign fill
//   conv_en     : 1 = output in sign-magnitude form
//   out_valid   : Result/ALUFlags valid
//   out_ready   : consumer accepts the result
//   Result      : registered result
//   ALUFlags    : registered {N,Z,C,V}
//============================================================================
module alu_shift_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    input  logic             arith,
    input  logic             conv_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] C_OP_ADD  = 3'b000;
    localparam logic [2:0] C_OP_SUB  = 3'b001;
    localparam logic [2:0] C_OP_AND  = 3'b010;
    localparam logic [2:0] C_OP_OR   = 3'b011;
    localparam logic [2:0] C_OP_XOR  = 3'b100;
    localparam logic [2:0] C_OP_NOR  = 3'b101;
    localparam logic [2:0] C_OP_PASS = 3'b110;

    localparam logic [SHW-1:0]   C_CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0]   C_CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ZERO     = '0;

    //------------------------------------------------------------------------
    // State and operand registers
    //------------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [SHW-1:0]     cnt_q,    cnt_d;
    logic [WIDTH-1:0]   a_q,      a_d;      // working (shifted) operand
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [2:0]         op_q,     op_d;
    logic               dir_q,    dir_d;
    logic               arith_q,  arith_d;
    logic               conv_q,   conv_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q,  flags_d;

    //------------------------------------------------------------------------
    // Datapath wires
    //------------------------------------------------------------------------
    logic [WIDTH-1:0]   w_shift_one;
    logic               w_fill;
    logic [WIDTH-1:0]   w_b_eff;
    logic               w_cin;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_raw;
    logic               w_c;
    logic               w_v;
    logic [WIDTH-2:0]   w_mag;
    logic [WIDTH-1:0]   w_conv;
    logic [3:0]         w_flags;

    //------------------------------------------------------------------------
    // One-bit shifter: left always zero-fills, right fills with the MSB
    // only for arithmetic shifts.
    //------------------------------------------------------------------------
    always_comb begin
        w_fill      = arith_q & a_q[WIDTH-1];
        w_shift_one = a_q;
        if (dir_q) begin
            w_shift_one = {w_fill, a_q[WIDTH-1:1]};
        end else begin
            w_shift_one = {a_q[WIDTH-2:0], 1'b0};
        end
    end

    //------------------------------------------------------------------------
    // ALU. ADD and SUB share one adder; SUB feeds ~b with a carry-in of 1,
    // so C is the "no borrow" carry and the overflow rule is the same as
    // for ADD on the effective operand.
    //------------------------------------------------------------------------
    always_comb begin
        w_b_eff = b_q;
        w_cin   = 1'b0;
        if (op_q == C_OP_SUB) begin
            w_b_eff = ~b_q;
            w_cin   = 1'b1;
        end
        w_sum = {1'b0, a_q} + {1'b0, w_b_eff} + {C_ZERO, w_cin};

        w_raw = C_ZERO;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op_q)
            C_OP_ADD, C_OP_SUB: begin
                w_raw = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a_q[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            C_OP_AND:  w_raw = a_q & b_q;
            C_OP_OR:   w_raw = a_q | b_q;
            C_OP_XOR:  w_raw = a_q ^ b_q;
            C_OP_NOR:  w_raw = ~(a_q | b_q);
            C_OP_PASS: w_raw = a_q;
            default:   w_raw = b_q;
        endcase

        w_flags = {w_raw[WIDTH-1], (w_raw == C_ZERO), w_c, w_v};
    end

    //------------------------------------------------------------------------
    // Sign-magnitude conversion. Only the low WIDTH-1 bits of the negation
    // are needed. The most negative value has no representable magnitude
    // and saturates to all ones.
    //------------------------------------------------------------------------
    always_comb begin
        w_mag  = (~w_raw[WIDTH-2:0]) + {{(WIDTH-2){1'b0}}, 1'b1};
        w_conv = w_raw;
        if (conv_q && w_raw[WIDTH-1]) begin
            if (w_raw[WIDTH-2:0] == '0) begin
                w_conv = {WIDTH{1'b1}};
            end else begin
                w_conv = {1'b1, w_mag};
            end
        end
    end

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        dir_d    = dir_q;
        arith_d  = arith_q;
        conv_d   = conv_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = ALUControl;
                    dir_d   = dir;
                    arith_d = arith;
                    conv_d  = conv_en;
                    cnt_d   = shamt;
                    state_d = (shamt != C_CNT_ZERO) ? ST_SHIFT : ST_EXEC;
                end
            end
            ST_SHIFT: begin
                a_d   = w_shift_one;
                cnt_d = cnt_q - C_CNT_ONE;
                if (cnt_q == C_CNT_ONE) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = w_conv;
                flags_d  = w_flags;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    //------------------------------------------------------------------------
    // Registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            dir_q    <= 1'b0;
            arith_q  <= 1'b0;
            conv_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            dir_q    <= dir_d;
            arith_q  <= arith_d;
            conv_q   <= conv_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign Result    = result_q;
    assign ALUFlags  = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_shift_seq.sv
`default_nettype none
//============================================================================
// Module      : tb_alu_shift_seq
// Description : Scoreboard bench for alu_shift_seq. Stimulus pushes the
//               hand-computed expected result for each request; a monitor
//               pops and compares on every output handshake.
// Revision    : 1.0 - initial release
//============================================================================
module tb_alu_shift_seq;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ALUControl;
    logic [SHW-1:0]   shamt;
    logic             dir;
    logic             arith;
    logic             conv_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic [3:0]       ALUFlags;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [3:0]       flg;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run;
    int   tests_failed;

    alu_shift_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .ALUControl (ALUControl),
        .shamt      (shamt),
        .dir        (dir),
        .arith      (arith),
        .conv_en    (conv_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .ALUFlags   (ALUFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic checker used by the stimulus process for control/timing.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares the output on each handshake against the queue head.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_output: got Result=0x%0h Flags=%b, expected no output",
                         Result, ALUFlags);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (Result !== e.res || ALUFlags !== e.flg) begin
                    tests_failed++;
                    $display("FAIL result: got Result=0x%0h Flags=%b, expected Result=0x%0h Flags=%b",
                             Result, ALUFlags, e.res, e.flg);
                end
            end
        end
    end

    // Present one request, wait for accept, return after the accept edge (+1).
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] op,
                         input logic [2:0] sh, input logic td, input logic tar, input logic tc);
        @(posedge clk); #1;
        a = ta; b = tb; ALUControl = op; shamt = sh; dir = td; arith = tar; conv_en = tc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble inputs: the operation must use the latched values.
        a = ~ta; b = ~tb; ALUControl = ~op; dir = ~td; arith = ~tar; conv_en = ~tc;
    endtask

    // Wait for out_valid, returning the number of edges since accept.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                         input logic [2:0] op, input logic [2:0] sh, input logic td,
                         input logic tar, input logic tc,
                         input logic [7:0] er, input logic [3:0] ef);
        int n;
        exp_t e;
        e.res = er;
        e.flg = ef;
        exp_q.push_back(e);
        out_ready = 1'b1;
        issue(ta, tb, op, sh, td, tar, tc);
        check({name, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        wait_valid(n);
        check({name, "_latency"}, n, sh + 1);
        @(posedge clk); #1;
        check({name, "_idle_after"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        int n;
        tests_run = 0; tests_failed = 0;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ALUControl = '0; shamt = '0; dir = 1'b0; arith = 1'b0; conv_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {17'd0, in_ready, out_valid, Result, ALUFlags, 1'b0},
              {17'd0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0});
        reset_n = 1'b1;

        //     name          a      b      op      sh    dir   ar    cv     Result  Flags
        do_op("add_ovf",    8'h7F, 8'h01, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 8'h80, 4'b1001);
        do_op("shl_xor",    8'h03, 8'h18, 3'b100, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0100);
        do_op("asr_sub_cv", 8'h80, 8'h00, 3'b001, 3'd2, 1'b1, 1'b1, 1'b1, 8'hA0, 4'b1010);
        do_op("asr_sub",    8'h80, 8'h00, 3'b001, 3'd2, 1'b1, 1'b1, 1'b0, 8'hE0, 4'b1010);
        do_op("sat_conv",   8'h80, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 8'hFF, 4'b1000);
        do_op("lsr_pass",   8'h80, 8'h55, 3'b110, 3'd7, 1'b1, 1'b0, 1'b0, 8'h01, 4'b0000);
        do_op("pass_b",     8'h12, 8'h80, 3'b111, 3'd1, 1'b0, 1'b0, 1'b0, 8'h80, 4'b1000);
        do_op("nor",        8'h0F, 8'hF0, 3'b101, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0100);
        do_op("asr_and",    8'hF0, 8'h3C, 3'b010, 3'd4, 1'b1, 1'b1, 1'b0, 8'h3C, 4'b0000);
        do_op("add_carry",  8'hFF, 8'h01, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0110);
        do_op("sub_borrow", 8'h01, 8'h02, 3'b001, 3'd0, 1'b0, 1'b0, 1'b1, 8'h81, 4'b1000);
        do_op("sub_vflag",  8'h80, 8'h01, 3'b001, 3'd0, 1'b0, 1'b0, 1'b0, 8'h7F, 4'b0011);

        // Backpressure: 0x0F << 1 = 0x1E, OR 0x01 = 0x1F.
        begin
            exp_t e;
            e.res = 8'h1F; e.flg = 4'b0000;
            exp_q.push_back(e);
        end
        out_ready = 1'b0;
        issue(8'h0F, 8'h01, 3'b011, 3'd1, 1'b0, 1'b0, 1'b0);
        wait_valid(n);
        check("bp_latency", n, 32'd2);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 8'hAA; b = 8'h55; shamt = 3'd0; ALUControl = 3'b000;
            @(posedge clk); #1;
            check("bp_hold", {19'd0, out_valid, in_ready, Result, ALUFlags},
                  {19'd0, 1'b1, 1'b0, 8'h1F, 4'h0});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_extra", {30'd0, in_ready, out_valid}, 32'b10);

        // Reset mid-SHIFT: no expectation pushed, the operation is aborted.
        issue(8'h55, 8'h0F, 3'b000, 3'd7, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_shift", {18'd0, out_valid, in_ready, Result, ALUFlags, 1'b0},
              {18'd0, 1'b0, 1'b1, 8'h00, 4'h0, 1'b0});
        @(posedge clk); #2;
        reset_n = 1'b1;
        do_op("sub_zero", 8'h05, 8'h05, 3'b001, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0110);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
